// File: rtl/fifo_pattern_fill_pkg.sv
// fifo_fill_pkg: mode encodings, FSM states and LFSR taps for the FIFO pattern filler
package fifo_fill_pkg;
  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_WALK  = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_FILL, S_GAP, S_DONE} state_t;
  // maximal-length Fibonacci tap masks, bit t-1 set for tap t
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0;
    endcase
  endfunction
endpackage

// File: rtl/fifo_pattern_fill_if.sv
// fifo_pattern_fill_if: control, FIFO direct-write and status signals of the pattern filler
interface fifo_pattern_fill_if #(parameter int DATA_W = 8, parameter int CNT_W = 13);
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;
  logic [CNT_W-1:0]  num_words;
  logic              buf_full;
  logic              direct_fifo;
  logic [DATA_W-1:0] direct_buf_in;
  logic              direct_wr_en_buf;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  words_written;
  modport master (
    input  start, abort, mode, seed, num_words, buf_full,
    output direct_fifo, direct_buf_in, direct_wr_en_buf, busy, done, words_written
  );
  modport slave (
    output start, abort, mode, seed, num_words, buf_full,
    input  direct_fifo, direct_buf_in, direct_wr_en_buf, busy, done, words_written
  );
endinterface

// File: rtl/fifo_pattern_fill_gen.sv
// fill_pattern_gen: holds the current fill word and steps it per accepted write
module fill_pattern_gen
  import fifo_fill_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] word
);
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] init, nxt;
  // an all-zero LFSR would lock up, so a zero seed starts from all-ones
  always_comb begin
    init = mode == MODE_WALK ? DATA_W'(1) : (mode == MODE_LFSR && seed == '0) ? '1 : seed;
    nxt  = mode_q == MODE_CONST ? word :
           mode_q == MODE_INC   ? word + 1'b1 :
           mode_q == MODE_LFSR  ? {word[DATA_W-2:0], ^(word & TAPS)} :
                                  {word[DATA_W-2:0], word[DATA_W-1]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word   <= '0;
      mode_q <= MODE_INC;
    end else if (load) begin
      word   <= init;
      mode_q <= mode;
    end else if (advance) begin
      word   <= nxt;
    end
endmodule

// File: rtl/fifo_pattern_fill.sv
// fifo_pattern_fill: takes over the FIFO direct write port and fills it with a chosen pattern
module fifo_pattern_fill
  import fifo_fill_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_COUNT = 5000,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1),
  parameter int GAP       = 0
) (
  input logic                 clk,
  input logic                 rst,
  fifo_pattern_fill_if.master bus
);
  state_t            state, nxt_state;
  logic [CNT_W-1:0]  count_q, ww, clamp;
  logic [7:0]        gap_cnt;
  logic              busy_q, fifo_q, done_q, wr, last, start_ok;
  logic [DATA_W-1:0] word;
  // strobe is the registered FILL intent qualified by this cycle's full and abort
  assign wr       = state == S_FILL && !bus.buf_full && !bus.abort;
  assign last     = ww + 1'b1 == count_q;
  assign start_ok = state == S_IDLE && bus.start;
  assign clamp    = bus.num_words > CNT_W'(MAX_COUNT) ? CNT_W'(MAX_COUNT) : bus.num_words;
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  nxt_state = bus.start ? S_ARB : S_IDLE;
      S_ARB:   nxt_state = (bus.abort || count_q == '0) ? S_DONE : S_FILL;
      S_FILL:  nxt_state = bus.abort ? S_DONE : !wr ? S_FILL : last ? S_DONE : GAP > 0 ? S_GAP : S_FILL;
      S_GAP:   nxt_state = bus.abort ? S_DONE : gap_cnt == 8'd0 ? S_FILL : S_GAP;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= S_IDLE;
      count_q <= '0;
      ww      <= '0;
      gap_cnt <= '0;
      busy_q  <= 1'b0;
      fifo_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= nxt_state;
      busy_q  <= nxt_state != S_IDLE;
      fifo_q  <= nxt_state inside {S_ARB, S_FILL, S_GAP};
      done_q  <= nxt_state == S_DONE;
      gap_cnt <= state == S_GAP ? gap_cnt - 8'd1 : 8'(GAP - 1);
      if (start_ok) begin
        count_q <= clamp;
        ww      <= '0;
      end else if (wr) begin
        ww      <= ww + 1'b1;
      end
    end
  fill_pattern_gen #(.DATA_W(DATA_W)) u_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .advance (wr),
    .mode    (bus.mode),
    .seed    (bus.seed),
    .word    (word)
  );
  assign bus.direct_fifo      = fifo_q;
  assign bus.direct_buf_in    = word;
  assign bus.direct_wr_en_buf = wr;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.words_written    = ww;
endmodule

// File: tb/tb_fifo_pattern_fill.sv
// tb_fifo_pattern_fill: directed tests of the pattern filler with GAP=0 and GAP=2 instances
module tb_fifo_pattern_fill;
  import fifo_fill_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_pattern_fill_if #(.DATA_W(8), .CNT_W(13)) f0 ();
  fifo_pattern_fill_if #(.DATA_W(8), .CNT_W(13)) f2 ();
  fifo_pattern_fill #(.DATA_W(8), .MAX_COUNT(5000), .GAP(0)) u0 (.clk(clk), .rst(rst), .bus(f0.master));
  fifo_pattern_fill #(.DATA_W(8), .MAX_COUNT(5000), .GAP(2)) u2 (.clk(clk), .rst(rst), .bus(f2.master));
  assign f2.start     = f0.start;
  assign f2.abort     = f0.abort;
  assign f2.mode      = f0.mode;
  assign f2.seed      = f0.seed;
  assign f2.num_words = f0.num_words;
  assign f2.buf_full  = f0.buf_full;
  int vecs = 0;
  int errs = 0;
  logic [7:0]  q_data[$];
  int          q_cyc[$];
  int          done_k;
  logic [12:0] done_ww;
  logic        busy_after, arb_df, done_df;
  // drives one run and records strobes; k counts cycles after the start edge
  task automatic run(input bit sel, input logic [1:0] m, input logic [7:0] sd, input logic [12:0] n,
                     input logic [63:0] full_mask, input int abort_k, input int start_k, input int budget);
    int w;
    logic wr, dn, df;
    logic [7:0] d;
    logic [12:0] ww;
    q_data.delete();
    q_cyc.delete();
    done_k = -1;
    done_ww = 'x;
    arb_df = 1'bx;
    done_df = 1'bx;
    w = 0;
    @(posedge clk); #1;
    while ((f0.busy || f2.busy) && w < 20000) begin
      @(posedge clk); #1;
      w++;
    end
    f0.mode = m;
    f0.seed = sd;
    f0.num_words = n;
    f0.start = 1'b1;
    @(posedge clk); #1;
    f0.start = 1'b0;
    for (int k = 1; k <= budget && done_k < 0; k++) begin
      f0.buf_full = k < 64 ? full_mask[k[5:0]] : 1'b0;
      f0.abort = k == abort_k;
      f0.start = k == start_k;
      #1;
      wr = sel ? f2.direct_wr_en_buf : f0.direct_wr_en_buf;
      dn = sel ? f2.done : f0.done;
      df = sel ? f2.direct_fifo : f0.direct_fifo;
      d  = sel ? f2.direct_buf_in : f0.direct_buf_in;
      ww = sel ? f2.words_written : f0.words_written;
      if (k == 1) arb_df = df;
      if (wr) begin
        q_data.push_back(d);
        q_cyc.push_back(k);
      end
      if (dn) begin
        done_k = k;
        done_ww = ww;
        done_df = df;
      end
      @(posedge clk); #1;
    end
    f0.buf_full = 1'b0;
    f0.abort = 1'b0;
    f0.start = 1'b0;
    busy_after = sel ? f2.busy : f0.busy;
  endtask
  task automatic test_reset();
    f0.start = 0; f0.abort = 0; f0.mode = 0; f0.seed = 0; f0.num_words = 0; f0.buf_full = 0;
    #1;
    vecs++;
    if ({f0.direct_fifo, f0.direct_wr_en_buf, f0.busy, f0.done} !== 4'b0) begin
      errs++; $display("FAIL reset_flags: got %b expected 0000", {f0.direct_fifo, f0.direct_wr_en_buf, f0.busy, f0.done});
    end
    vecs++;
    if (f0.direct_buf_in !== 8'h00 || f0.words_written !== 13'd0) begin
      errs++; $display("FAIL reset_data: got buf_in=%h ww=%0d expected 00/0", f0.direct_buf_in, f0.words_written);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (f0.busy !== 1'b0 || f2.busy !== 1'b0) begin
      errs++; $display("FAIL reset_idle: got busy=%b/%b expected 0/0", f0.busy, f2.busy);
    end
  endtask
  task automatic test_increment();
    logic [7:0] exp_d [5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    run(0, MODE_INC, 8'hFE, 13'd5, 64'h0, -1, -1, 50);
    vecs++;
    if (q_data.size() !== 5) begin errs++; $display("FAIL inc_count: got %0d expected 5", q_data.size()); end
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (q_data[i] !== exp_d[i] || q_cyc[i] !== i + 2) begin
        errs++; $display("FAIL inc_word%0d: got %h@%0d expected %h@%0d", i, q_data[i], q_cyc[i], exp_d[i], i + 2);
      end
    end
    vecs++;
    if (done_k !== 7 || done_ww !== 13'd5) begin
      errs++; $display("FAIL inc_done: got k=%0d ww=%0d expected k=7 ww=5", done_k, done_ww);
    end
    vecs++;
    if (arb_df !== 1'b1 || done_df !== 1'b0) begin
      errs++; $display("FAIL inc_ownership: got arb=%b done=%b expected 1/0", arb_df, done_df);
    end
  endtask
  task automatic test_lfsr();
    logic [7:0] exp_d [6] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
    logic [7:0] x;
    bit seen [256];
    int bad, dup;
    run(0, MODE_LFSR, 8'h00, 13'd255, 64'h0, -1, -1, 400);
    vecs++;
    if (q_data.size() !== 255 || done_ww !== 13'd255) begin
      errs++; $display("FAIL lfsr_count: got %0d/%0d expected 255", q_data.size(), done_ww);
    end
    for (int i = 0; i < 6; i++) begin
      vecs++;
      if (q_data[i] !== exp_d[i]) begin errs++; $display("FAIL lfsr_word%0d: got %h expected %h", i, q_data[i], exp_d[i]); end
    end
    x = 8'hFF;
    bad = 0;
    dup = 0;
    for (int i = 0; i < q_data.size(); i++) begin
      if (q_data[i] !== x) bad++;
      if (seen[q_data[i]]) dup++;
      seen[q_data[i]] = 1'b1;
      x = {x[6:0], ^(x & 8'hB8)};
    end
    vecs++;
    if (bad !== 0 || dup !== 0) begin
      errs++; $display("FAIL lfsr_sequence: got %0d wrong %0d repeated expected 0/0", bad, dup);
    end
  endtask
  task automatic test_gap();
    logic [7:0] exp_d [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    run(1, MODE_WALK, 8'h33, 13'd10, 64'h0, -1, -1, 100);
    vecs++;
    if (q_data.size() !== 10) begin errs++; $display("FAIL gap_count: got %0d expected 10", q_data.size()); end
    for (int i = 0; i < 10; i++) begin
      vecs++;
      if (q_data[i] !== exp_d[i] || q_cyc[i] !== 2 + 3 * i) begin
        errs++; $display("FAIL gap_word%0d: got %h@%0d expected %h@%0d", i, q_data[i], q_cyc[i], exp_d[i], 2 + 3 * i);
      end
    end
    vecs++;
    if (q_cyc[9] - q_cyc[0] + 1 !== 28) begin
      errs++; $display("FAIL gap_span: got %0d expected 28", q_cyc[9] - q_cyc[0] + 1);
    end
    vecs++;
    if (done_k !== 30 || done_ww !== 13'd10) begin
      errs++; $display("FAIL gap_done: got k=%0d ww=%0d expected k=30 ww=10", done_k, done_ww);
    end
  endtask
  task automatic test_backpressure();
    int exp_c [4] = '{2, 7, 8, 9};
    run(0, MODE_CONST, 8'hA5, 13'd4, 64'h78, -1, -1, 50);
    vecs++;
    if (q_data.size() !== 4) begin errs++; $display("FAIL bp_count: got %0d expected 4", q_data.size()); end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (q_data[i] !== 8'hA5 || q_cyc[i] !== exp_c[i]) begin
        errs++; $display("FAIL bp_word%0d: got %h@%0d expected a5@%0d", i, q_data[i], q_cyc[i], exp_c[i]);
      end
    end
    vecs++;
    if (done_k !== 10 || done_ww !== 13'd4) begin
      errs++; $display("FAIL bp_done: got k=%0d ww=%0d expected k=10 ww=4", done_k, done_ww);
    end
  endtask
  task automatic test_zero_count();
    run(0, MODE_INC, 8'h07, 13'd0, 64'h0, -1, 2, 20);
    vecs++;
    if (q_data.size() !== 0) begin errs++; $display("FAIL zero_strobes: got %0d expected 0", q_data.size()); end
    vecs++;
    if (done_k !== 2 || done_ww !== 13'd0 || arb_df !== 1'b1) begin
      errs++; $display("FAIL zero_done: got k=%0d ww=%0d arb=%b expected k=2 ww=0 arb=1", done_k, done_ww, arb_df);
    end
    vecs++;
    if (busy_after !== 1'b0) begin errs++; $display("FAIL start_at_done: got busy=%b expected 0", busy_after); end
  endtask
  task automatic test_abort();
    run(0, MODE_INC, 8'h10, 13'd10, 64'h0, 5, 3, 50);
    vecs++;
    if (q_data.size() !== 3 || q_data[0] !== 8'h10 || q_data[1] !== 8'h11 || q_data[2] !== 8'h12) begin
      errs++; $display("FAIL abort_words: got %0d words expected 3 (10,11,12)", q_data.size());
    end
    vecs++;
    if (done_k !== 6 || done_ww !== 13'd3) begin
      errs++; $display("FAIL abort_done: got k=%0d ww=%0d expected k=6 ww=3", done_k, done_ww);
    end
    vecs++;
    if (busy_after !== 1'b0) begin errs++; $display("FAIL abort_idle: got busy=%b expected 0", busy_after); end
  endtask
  task automatic test_max_count();
    run(0, MODE_INC, 8'h00, 13'd6000, 64'h0, -1, -1, 5100);
    vecs++;
    if (q_data.size() !== 5000 || done_ww !== 13'd5000) begin
      errs++; $display("FAIL max_count: got %0d/%0d expected 5000", q_data.size(), done_ww);
    end
    vecs++;
    if (q_data[4999] !== 8'h87 || done_k !== 5002) begin
      errs++; $display("FAIL max_last: got %h k=%0d expected 87 k=5002", q_data[4999], done_k);
    end
  endtask
  task automatic test_reset_mid_run();
    int dn;
    @(posedge clk); #1;
    f0.mode = MODE_INC;
    f0.seed = 8'h40;
    f0.num_words = 13'd20;
    f0.start = 1'b1;
    @(posedge clk); #1;
    f0.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vecs++;
    if (f0.direct_wr_en_buf !== 1'b1 || f0.words_written === 13'd0) begin
      errs++; $display("FAIL rst_prerun: got wr=%b ww=%0d expected writing", f0.direct_wr_en_buf, f0.words_written);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({f0.direct_fifo, f0.direct_wr_en_buf, f0.busy, f0.done} !== 4'b0 || f0.direct_buf_in !== 8'h00 || f0.words_written !== 13'd0) begin
      errs++; $display("FAIL rst_async: got flags=%b buf_in=%h ww=%0d expected 0", {f0.direct_fifo, f0.direct_wr_en_buf, f0.busy, f0.done}, f0.direct_buf_in, f0.words_written);
    end
    @(posedge clk); #1 rst = 1'b0;
    dn = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (f0.done || f0.busy || f2.done || f2.busy) dn++;
    end
    vecs++;
    if (dn !== 0) begin errs++; $display("FAIL rst_no_done: got %0d active cycles expected 0", dn); end
  endtask
  initial begin
    test_reset();
    test_increment();
    test_lfsr();
    test_gap();
    test_backpressure();
    test_zero_count();
    test_abort();
    test_max_count();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fifo_pattern_fill.md
# fifo_pattern_fill

Parametrised successor to the bench FIFO auto-filler. On a `start` pulse it takes ownership of the collection block's direct FIFO write port and writes a programmable number of words in one of four data patterns. It honours FIFO back-pressure, supports inter-write gaps and abort, and reports completion. It sits beside `collection` in SPI write benches and in self-test builds, driving `direct_fifo`, `direct_buf_in` and `direct_wr_en_buf`.

## Interface
- `DATA_W`, 8: FIFO word width (4..32).
- `MAX_COUNT`, 5000: largest word count per run.
- `CNT_W`, $clog2(MAX_COUNT+1): count width.
- `GAP`, 0: idle cycles inserted after every write (0..255).

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `abort`  in  1  terminate the current run; sampled in ARB/FILL/GAP.
- `mode`  in  2  pattern: 0 increment, 1 constant, 2 LFSR, 3 walking-one; latched at start.
- `seed`  in  DATA_W  initial word for modes 0/1/2; latched at start.
- `num_words`  in  CNT_W  words to write; latched at start.
- `buf_full`  in  1  FIFO full; a write is suppressed while high.
- `direct_fifo`  out  1  high while the block owns the FIFO write port.
- `direct_buf_in`  out  DATA_W  write data.
- `direct_wr_en_buf`  out  1  write strobe, one word per high cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of a run (normal or aborted).
- `words_written`  out  CNT_W  words accepted in the current/last run.

## Operation
- States: IDLE, ARB, FILL, GAP, DONE.
- IDLE -> ARB on `start`. Latch mode, seed and count. Count = min(`num_words`, `MAX_COUNT`). Clear `words_written`.
- ARB: one cycle with `direct_fifo`=1. Gives the downstream mux a cycle to switch. Count 0 -> DONE, else FILL.
- FILL: `direct_wr_en_buf` = !`buf_full`.
  - On a write: advance the pattern and increment `words_written`.
  - Next state after a write: DONE if this was the last word, GAP if `GAP`>0, otherwise stay in FILL.
  - While `buf_full` is high: hold data, strobe low, no timeout.
- GAP: strobe low for exactly `GAP` cycles, then FILL.
- DONE: `done`=1 and `direct_fifo`=0 for one cycle, then IDLE.
- `abort` in ARB/FILL/GAP -> DONE next cycle. No write occurs in the abort cycle: abort has priority over the write.
- `start` while `busy` is ignored. A `start` coincident with DONE is ignored.
- Patterns, per accepted write:
  - Increment: seed, seed+1, … modulo 2^DATA_W, wraps silently.
  - Constant: seed every word.
  - LFSR: Fibonacci, maximal-length taps per `DATA_W` from the package. A seed of 0 is replaced by all-ones.
  - Walking-one: 1, 2, 4, … rotate left, wraps to 1 after the MSB; seed ignored.
- `direct_buf_in` is valid whenever the strobe is high. It holds its value otherwise.

## Timing
- All outputs are registered.
- Reset values: `direct_fifo`=0, `direct_buf_in`=0, `direct_wr_en_buf`=0, `busy`=0, `done`=0, `words_written`=0, state IDLE.
- `start` high at edge T:
  - ARB visible after T (`busy`=1, `direct_fifo`=1).
  - First strobe is possible in the cycle after ARB, i.e. 2 cycles after T.
- Throughput: N words, `GAP`=g, no full -> N·(1+g) − g cycles from first strobe to last strobe. `done` follows the last strobe by 1 cycle.
- Back-pressure: `buf_full` is sampled the same cycle the strobe is generated (combinational qualify of a registered intent).
- Reset mid-run: all outputs return to reset values immediately (asynchronous). No `done` pulse. The partial FIFO contents are the FIFO's concern.

## Structure
- `fifo_fill_pkg` holds:
  - the mode encoding constants;
  - the state enum;
  - the LFSR tap function for `DATA_W` 4..32.
- One sub-module, `fill_pattern_gen`:
  - loads seed/mode;
  - produces the current word;
  - steps on an `advance` input.
  The top block keeps the FSM, counters and gap timer.

## Test plan
- Mode 0, seed 8'hFE, 5 words, `GAP`=0, never full -> strobes on 5 consecutive cycles with FE, FF, 00, 01, 02; `done` one cycle later; `words_written`=5.
- Mode 2, seed 0, `DATA_W`=8 -> first word 8'hFF. Sequence matches the package taps; no repeat within 255 words.
- Mode 3, 10 words, `GAP`=2 -> 01,02,04,…,80,01,02 with exactly 2 idle cycles between strobes; 28 cycles from first to last strobe.
- Mode 1, seed 8'hA5, 4 words, `buf_full` high for cycles 2–5 of FILL -> no strobe while full; 4 A5 writes total; `done` delayed by 4 cycles.
- `num_words`=6000 with `MAX_COUNT`=5000 -> 5000 writes. `num_words`=0 -> IDLE, ARB, DONE with no strobe and `words_written`=0.
- Abort after 3 writes -> no 4th strobe; `done` next cycle; `words_written`=3. `start` during the run is ignored. `rst` asserted mid-run -> all outputs 0 at once, no `done`.
